// File: rtl/rr_fifo_arbiter.sv
// rr_fifo_arbiter: round-robin 4-input FIFO arbiter routing head words to 4 output FIFOs by destination bits.
module rr_fifo_arbiter #(
    parameter int DATA_W = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [3:0]            in_empty,
    input  logic [4*DATA_W-1:0]   in_data,
    input  logic [3:0]            out_afull,
    output logic [3:0]            pop,
    output logic [3:0]            push,
    output logic [DATA_W-1:0]     data_out,
    output logic [1:0]            grant_id,
    output logic                  busy,
    output logic [31:0]           push_cnt
);
    logic [DATA_W-1:0] word [4];
    logic [1:0]        dest [4];
    logic [3:0]        elig;
    logic [1:0]        rr_q, rr_d, win, idx, grant_id_q, grant_id_d;
    logic              found, busy_q, busy_d;
    logic [3:0]        push_q, push_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [7:0]        cnt_q [4];
    logic [7:0]        cnt_d [4];

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign word[g] = in_data[g*DATA_W +: DATA_W];
        assign dest[g] = word[g][DATA_W-1 -: 2];
        assign elig[g] = enable & ~in_empty[g] & ~out_afull[dest[g]];
        assign push_cnt[g*8 +: 8] = cnt_q[g];
    end

    // first eligible index scanning upward from the round-robin pointer
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = '0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_q + 2'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end

    always_comb begin
        pop        = (found && !reset) ? 4'b0001 << win : 4'b0000;
        push_d     = found ? 4'b0001 << dest[win] : 4'b0000;
        data_out_d = found ? word[win] : data_out_q;
        grant_id_d = found ? win : grant_id_q;
        rr_d       = found ? win + 2'd1 : rr_q;
        busy_d     = |push_q;
        for (int j = 0; j < 4; j++) cnt_d[j] = cnt_q[j] + {7'd0, push_d[j]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q       <= '0;
            push_q     <= '0;
            data_out_q <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            for (int j = 0; j < 4; j++) cnt_q[j] <= '0;
        end else begin
            rr_q       <= rr_d;
            push_q     <= push_d;
            data_out_q <= data_out_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            for (int j = 0; j < 4; j++) cnt_q[j] <= cnt_d[j];
        end
    end

    assign push     = push_q;
    assign data_out = data_out_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
endmodule

// File: doc/rr_fifo_arbiter.md
RR_FIFO_ARBITER -- requirements
Module: rr_fifo_arbiter

Interface
REQ-001 Parameter DATA_W SHALL default to 10 and set the data word width; bits [DATA_W-1:DATA_W-2] of a word are its destination (0-3).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  arbitration allowed; driven high by the flow-control FSM while ACTIVE.
REQ-005 in_empty  input  4  empty flags of input FIFOs 0-3 (show-ahead FIFOs: head word valid whenever empty=0).
REQ-006 in_data  input  4*DATA_W  head words; FIFO i occupies bits [i*DATA_W +: DATA_W].
REQ-007 out_afull  input  4  almost-full flags of output FIFOs 0-3, generated against the alto threshold.
REQ-008 pop  output  4  one-hot-or-zero read strobe to the input FIFOs, combinational.
REQ-009 push  output  4  one-hot-or-zero write strobe to the output FIFOs, registered.
REQ-010 data_out  output  DATA_W  registered word accompanying push.
REQ-011 grant_id  output  2  registered index of the input FIFO serviced by the current push.
REQ-012 busy  output  1  registered; 1 when a push occurred in the previous cycle.
REQ-013 push_cnt  output  4*8  per-output-FIFO 8-bit push counters; counter j occupies bits [j*8 +: 8].

Function
REQ-014 eligible[i] SHALL equal enable AND NOT in_empty[i] AND NOT out_afull[dest(in_data word i)], evaluated from same-cycle inputs.
REQ-015 The arbiter SHALL hold a 2-bit round-robin pointer rr_ptr; the winner is the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo 4.
REQ-016 Arbitration SHALL be work-conserving: an input blocked by an almost-full destination is skipped; it does not block the other inputs.
REQ-017 pop[winner] SHALL be 1 in the winning cycle; pop SHALL be 4'b0000 when no index is eligible, and whenever reset=1.
REQ-018 Pipeline latency SHALL be 1 cycle: on the edge after pop[i], push[dest]=1, data_out=the popped word, grant_id=i.
REQ-019 With no winner, push SHALL be 0 on the next cycle; data_out and grant_id SHALL hold their previous values.
REQ-020 After a grant to index i, rr_ptr SHALL become (i+1) mod 4 (3 wraps to 0); rr_ptr SHALL be unchanged when no grant occurs.
REQ-021 Sustained throughput SHALL be one word per cycle when any input is eligible.
REQ-022 push_cnt[j] SHALL increment by 1 on each registered push to output j and wrap from 255 to 0 without saturating or flagging.
REQ-023 If out_afull[d] rises in the same cycle as a candidate word for d, that word SHALL NOT be granted in that cycle.
REQ-024 Deasserting enable SHALL stop new pops in the same cycle; a push already registered SHALL still complete on the following edge.
REQ-025 A word SHALL never be popped without exactly one matching push on the next edge, unless reset is asserted at that edge.

Reset
REQ-026 While reset=1 at a rising edge: rr_ptr=0, push=0, data_out=0, grant_id=0, busy=0, all push_cnt=0.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight word (push=0 after the edge); pop SHALL be 0 throughout reset.
REQ-028 The first arbitration after reset SHALL start from index 0.

Verification
REQ-029 Reset, enable=1, in_empty=4'b0000, all words destined to 0, out_afull=0 -> pops in order 0,1,2,3,0...; push=4'b0001 every cycle from cycle 2; push_cnt[0] increments 1 per cycle.
REQ-030 Only FIFO 2 non-empty, word 10'b11_0000_0101 -> pop=4'b0100, next cycle push=4'b1000, data_out=10'h305, grant_id=2, rr_ptr=3.
REQ-031 FIFOs 0 and 1 non-empty, dest(0)=1, dest(1)=2, out_afull=4'b0010 -> FIFO 1 granted, FIFO 0 skipped until out_afull[1] falls.
REQ-032 Continuous pushes to output 3 for 256 cycles -> push_cnt[3] reads 0 after the 256th push (wrap) with no other counter affected.
REQ-033 Reset asserted the cycle after a pop -> push stays 0, all outputs at reset values, pop=0 during reset; first grant after release goes to index 0.
REQ-034 enable toggled 1->0 mid-stream -> pop=0 in the same cycle, exactly one trailing push, then push=0 until enable returns.
